seg7_countdown_monitor: RTL and testbench

//  Receive-side checker for the 7-segment countdown display bus. Samples the

---
 rtl/seg7_pkg.sv | 54 +++++
 rtl/seg7_countdown_monitor_if.sv | 14 +
 rtl/seg7_stable_filter.sv | 41 ++++
 rtl/seg7_countdown_monitor.sv | 77 +++++++
 tb/tb_seg7_countdown_monitor.sv | 130 +++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment encodings, decode helper and monitor FSM states.
package seg7_pkg;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] value;
    } seg7_dec_t;

    function automatic seg7_dec_t seg7_decode(input logic [6:0] p);
        seg7_dec_t r;
        r = '{legal: 1'b1, blank: 1'b0, value: 4'h0};
        case (p)
            SEG_0:     r.value = 4'h0;
            SEG_1:     r.value = 4'h1;
            SEG_2:     r.value = 4'h2;
            SEG_3:     r.value = 4'h3;
            SEG_4:     r.value = 4'h4;
            SEG_5:     r.value = 4'h5;
            SEG_6:     r.value = 4'h6;
            SEG_7:     r.value = 4'h7;
            SEG_8:     r.value = 4'h8;
            SEG_9:     r.value = 4'h9;
            SEG_A:     r.value = 4'hA;
            SEG_B:     r.value = 4'hB;
            SEG_C:     r.value = 4'hC;
            SEG_D:     r.value = 4'hD;
            SEG_E:     r.value = 4'hE;
            SEG_F:     r.value = 4'hF;
            SEG_BLANK: r = '{legal: 1'b0, blank: 1'b1, value: 4'h0};
            default:   r.legal = 1'b0;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/seg7_countdown_monitor_if.sv
// seg7_countdown_monitor_if: display bus input plus checker result signals.
interface seg7_countdown_monitor_if;
    logic [6:0] seg;
    logic       clear;
    logic [3:0] digit;
    logic       digit_valid;
    logic [3:0] step_count;
    logic       done;
    logic       step_err;
    logic       illegal;

    modport master (output seg, clear, input digit, digit_valid, step_count, done, step_err, illegal);
    modport slave  (input seg, clear, output digit, digit_valid, step_count, done, step_err, illegal);
endinterface

// File: rtl/seg7_stable_filter.sv
// seg7_stable_filter: flags a pattern once it has been sampled STABLE_CYCLES times in a row
// and differs from the previously accepted pattern.
module seg7_stable_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] seg,
    output logic       accept,
    output logic [6:0] pattern
);
    logic [6:0]       held;
    logic [6:0]       last;
    logic             last_vld;
    logic [CNT_W-1:0] cnt;
    logic             same;
    logic             reach;

    assign same    = seg == held;
    // reach is the edge that brings the run of identical samples to exactly STABLE_CYCLES
    assign reach   = (STABLE_CYCLES == 1) ? !same : same && cnt == CNT_W'(STABLE_CYCLES - 2);
    assign accept  = reach && (!last_vld || seg != last);
    assign pattern = seg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held     <= 7'h7F;
            cnt      <= '0;
            last     <= 7'h7F;
            last_vld <= 1'b0;
        end else begin
            held <= seg;
            cnt  <= !same ? '0 : (cnt == CNT_W'(STABLE_CYCLES - 1)) ? cnt : cnt + 1'b1;
            if (accept) begin
                last     <= seg;
                last_vld <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/seg7_countdown_monitor.sv
// seg7_countdown_monitor: decodes stable 7-segment patterns and checks a countdown to 0.
module seg7_countdown_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input logic                      clock,
    input logic                      reset,
    seg7_countdown_monitor_if.slave  bus
);
    logic       accept;
    logic [6:0] pattern;
    seg7_dec_t  dec;
    state_t     state, state_n;
    logic [3:0] digit_n, count_n;
    logic       valid_n, err_n, ill_n;

    seg7_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_filter (
        .clock   (clock),
        .reset   (reset),
        .seg     (bus.seg),
        .accept  (accept),
        .pattern (pattern)
    );

    assign bus.done = state == DONE;

    always_comb begin
        dec     = seg7_decode(pattern);
        state_n = state;
        digit_n = bus.digit;
        count_n = bus.step_count;
        valid_n = 1'b0;
        err_n   = bus.step_err;
        ill_n   = bus.illegal;
        if (bus.clear) begin
            state_n = IDLE;
            count_n = '0;
            err_n   = 1'b0;
            ill_n   = 1'b0;
        end else if (accept && dec.legal) begin
            valid_n = 1'b1;
            digit_n = dec.value;
            state_n = (dec.value == 4'h0) ? DONE : TRACK;
            // IDLE and DONE both start a fresh sequence
            if (state == TRACK) begin
                if (dec.value == bus.digit - 4'd1)
                    count_n = (bus.step_count == 4'hF) ? 4'hF : bus.step_count + 4'd1;
                else
                    err_n = 1'b1;
            end else begin
                count_n = '0;
            end
        end else if (accept && !dec.blank) begin
            ill_n = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            bus.digit       <= '0;
            bus.digit_valid <= 1'b0;
            bus.step_count  <= '0;
            bus.step_err    <= 1'b0;
            bus.illegal     <= 1'b0;
        end else begin
            state           <= state_n;
            bus.digit       <= digit_n;
            bus.digit_valid <= valid_n;
            bus.step_count  <= count_n;
            bus.step_err    <= err_n;
            bus.illegal     <= ill_n;
        end
    end
endmodule

// File: tb/tb_seg7_countdown_monitor.sv
// tb_seg7_countdown_monitor: table-driven directed check of the countdown monitor.
module tb_seg7_countdown_monitor;
    typedef struct {
        logic [6:0] seg;
        logic       clr;
        int         n;
        int         pulses;
        logic [3:0] digit;
        logic [3:0] sc;
        logic       done;
        logic       err;
        logic       ill;
    } vec_t;

    localparam logic [6:0] PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAD   = 7'b0101010;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_bad;
    vec_t v[$];
    int   split;

    seg7_countdown_monitor_if bus ();

    seg7_countdown_monitor #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [6:0] s, input logic c, input int n, input int p,
                                input logic [3:0] d, input logic [3:0] sc, input logic dn,
                                input logic e, input logic il);
        vec_t t;
        t = '{seg: s, clr: c, n: n, pulses: p, digit: d, sc: sc, done: dn, err: e, ill: il};
        return t;
    endfunction

    task automatic check(input string name, input vec_t e, input int p);
        n_vec++;
        if (p != e.pulses || bus.digit !== e.digit || bus.step_count !== e.sc ||
            bus.done !== e.done || bus.step_err !== e.err || bus.illegal !== e.ill) begin
            n_bad++;
            $display("FAIL %s: got pulses=%0d digit=%h sc=%0d done=%b err=%b ill=%b, want pulses=%0d digit=%h sc=%0d done=%b err=%b ill=%b",
                     name, p, bus.digit, bus.step_count, bus.done, bus.step_err, bus.illegal,
                     e.pulses, e.digit, e.sc, e.done, e.err, e.ill);
        end
    endtask

    task automatic run(input int i);
        int p;
        p = 0;
        bus.seg   = v[i].seg;
        bus.clear = v[i].clr;
        repeat (v[i].n) begin
            @(posedge clock);
            #1;
            p += int'(bus.digit_valid);
        end
        check($sformatf("vec%0d", i), v[i], p);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        // full countdown F..0
        for (int d = 15; d >= 0; d--)
            v.push_back(mk(PAT[d], 1'b0, 10, 1, 4'(d), 4'(15 - d), d == 0, 1'b0, 1'b0));
        // short E glitch ignored, F restarts from DONE, pulse lasts one cycle
        v.push_back(mk(PAT[14], 1'b0, 3, 0, 4'h0, 4'd15, 1'b1, 1'b0, 1'b0));
        v.push_back(mk(PAT[15], 1'b0, 4, 1, 4'hF, 4'd0, 1'b0, 1'b0, 1'b0));
        v.push_back(mk(PAT[15], 1'b0, 1, 0, 4'hF, 4'd0, 1'b0, 1'b0, 1'b0));
        // F,E,C skip
        v.push_back(mk(PAT[14], 1'b0, 10, 1, 4'hE, 4'd1, 1'b0, 1'b0, 1'b0));
        v.push_back(mk(PAT[12], 1'b0, 10, 1, 4'hC, 4'd1, 1'b0, 1'b1, 1'b0));
        // illegal pattern then clear
        v.push_back(mk(BAD, 1'b0, 10, 0, 4'hC, 4'd1, 1'b0, 1'b1, 1'b1));
        v.push_back(mk(BAD, 1'b1, 1, 0, 4'hC, 4'd0, 1'b0, 1'b0, 1'b0));
        v.push_back(mk(BAD, 1'b0, 2, 0, 4'hC, 4'd0, 1'b0, 1'b0, 1'b0));
        // 5, blank, 5: second 5 is re-accepted and is a step error
        v.push_back(mk(PAT[5], 1'b0, 10, 1, 4'h5, 4'd0, 1'b0, 1'b0, 1'b0));
        v.push_back(mk(BLANK, 1'b0, 10, 0, 4'h5, 4'd0, 1'b0, 1'b0, 1'b0));
        v.push_back(mk(PAT[5], 1'b0, 10, 1, 4'h5, 4'd0, 1'b0, 1'b1, 1'b0));
        // clear on the accept edge of 9 drops it; 9 stays marked accepted
        v.push_back(mk(PAT[9], 1'b0, 3, 0, 4'h5, 4'd0, 1'b0, 1'b1, 1'b0));
        v.push_back(mk(PAT[9], 1'b1, 1, 0, 4'h5, 4'd0, 1'b0, 1'b0, 1'b0));
        v.push_back(mk(PAT[9], 1'b0, 5, 0, 4'h5, 4'd0, 1'b0, 1'b0, 1'b0));
        v.push_back(mk(PAT[8], 1'b0, 10, 1, 4'h8, 4'd0, 1'b0, 1'b0, 1'b0));
        v.push_back(mk(PAT[7], 1'b0, 10, 1, 4'h7, 4'd1, 1'b0, 1'b0, 1'b0));
        split = v.size();
        // after mid-sequence reset, 6 is an IDLE accept and 5 then tracks
        v.push_back(mk(PAT[6], 1'b0, 5, 1, 4'h6, 4'd0, 1'b0, 1'b0, 1'b0));
        v.push_back(mk(PAT[5], 1'b0, 10, 1, 4'h5, 4'd1, 1'b0, 1'b0, 1'b0));

        reset     = 1'b0;
        bus.seg   = BLANK;
        bus.clear = 1'b0;
        #3;
        check("reset", mk(BLANK, 1'b0, 0, 0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0), int'(bus.digit_valid));
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < split; i++) run(i);

        bus.seg = PAT[6];
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #2;
        check("async_reset", mk(BLANK, 1'b0, 0, 0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0), int'(bus.digit_valid));
        reset = 1'b1;

        for (int i = split; i < v.size(); i++) run(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
